// File: rtl/vec_scalar_div_if.sv
// Handshake and data bus of the vector-by-scalar divider.
interface vec_scalar_div_if #(
  parameter int WIDTH = 32,
  parameter int SIZE  = 4
);
  logic                    start;
  logic [WIDTH-1:0]        d;
  logic [WIDTH*SIZE-1:0]   b;
  logic [WIDTH*SIZE-1:0]   y;
  logic                    busy;
  logic                    done;
  logic                    div0;

  modport master (output start, d, b, input y, busy, done, div0);
  modport slave  (input start, d, b, output y, busy, done, div0);
endinterface

// File: rtl/vec_scalar_div.sv
// Sequential Q(WIDTH-FRAC).FRAC vector / scalar divider: one restoring
// radix-2 division per element, elements processed in index order.
module vec_scalar_div #(
  parameter int WIDTH = 32,
  parameter int SIZE  = 4,
  parameter int FRAC  = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  vec_scalar_div_if.slave bus
);
  localparam int QW = WIDTH + FRAC;
  localparam int CW = $clog2(QW + 1);
  localparam int IW = (SIZE > 1) ? $clog2(SIZE) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_ITER  = 3'd2;
  localparam logic [2:0] S_STORE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [WIDTH-1:0] MAXP = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MINN = {1'b1, {(WIDTH-1){1'b0}}};

  logic [2:0]                  state;
  logic [SIZE-1:0][WIDTH-1:0]  b_r;
  logic [SIZE-1:0][WIDTH-1:0]  y_r;
  logic [WIDTH-1:0]            mag_d;
  logic                        d_neg;
  logic                        neg;
  logic                        div0_r;
  logic [QW-1:0]               num;
  logic [QW-1:0]               quo;
  logic [WIDTH:0]              rem;
  logic [CW-1:0]               cnt;
  logic [IW-1:0]               idx;

  logic [WIDTH-1:0]            b_cur;
  logic [WIDTH-1:0]            mag_b;
  logic [WIDTH:0]              rem_sh;
  logic                        ge;
  logic                        pos_ovf;
  logic                        neg_ovf;
  logic [WIDTH-1:0]            res;

  assign b_cur  = b_r[idx];
  assign mag_b  = b_cur[WIDTH-1] ? -b_cur : b_cur;
  assign rem_sh = {rem[WIDTH-1:0], num[QW-1]};
  assign ge     = rem_sh >= {1'b0, mag_d};

  // Negative results may reach exactly 2^(WIDTH-1); positive ones may not.
  assign pos_ovf = (|quo[QW-1:WIDTH]) | quo[WIDTH-1];
  assign neg_ovf = (|quo[QW-1:WIDTH]) | (quo[WIDTH-1] & (|quo[WIDTH-2:0]));

  always_comb begin
    res = '0;
    if (div0_r) begin
      if (b_cur[WIDTH-1])   res = MINN;
      else if (|b_cur)      res = MAXP;
    end else if (neg) begin
      res = neg_ovf ? MINN : -quo[WIDTH-1:0];
    end else begin
      res = pos_ovf ? MAXP : quo[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      b_r    <= '0;
      y_r    <= '0;
      mag_d  <= '0;
      d_neg  <= 1'b0;
      neg    <= 1'b0;
      div0_r <= 1'b0;
      num    <= '0;
      quo    <= '0;
      rem    <= '0;
      cnt    <= '0;
      idx    <= '0;
    end else begin
      case (state)
        S_IDLE: if (bus.start) begin
          b_r    <= bus.b;
          mag_d  <= bus.d[WIDTH-1] ? -bus.d : bus.d;
          d_neg  <= bus.d[WIDTH-1];
          div0_r <= (bus.d == '0);
          idx    <= '0;
          state  <= S_LOAD;
        end
        S_LOAD: begin
          neg   <= b_cur[WIDTH-1] ^ d_neg;
          num   <= {mag_b, {FRAC{1'b0}}};
          rem   <= '0;
          quo   <= '0;
          cnt   <= CW'(QW);
          state <= S_ITER;
        end
        S_ITER: begin
          num <= num << 1;
          if (ge) begin
            rem <= rem_sh - {1'b0, mag_d};
            quo <= {quo[QW-2:0], 1'b1};
          end else begin
            rem <= rem_sh;
            quo <= {quo[QW-2:0], 1'b0};
          end
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= S_STORE;
        end
        S_STORE: begin
          y_r[idx] <= res;
          if (idx == IW'(SIZE - 1)) begin
            state <= S_DONE;
          end else begin
            idx   <= idx + IW'(1);
            state <= S_LOAD;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.y    = y_r;
  assign bus.busy = (state == S_LOAD) || (state == S_ITER) || (state == S_STORE);
  assign bus.done = (state == S_DONE);
  assign bus.div0 = div0_r;
endmodule

// File: tb/tb_vec_scalar_div.sv
// Randomized and directed checks of vec_scalar_div against an
// integer-arithmetic reference model.
module tb_vec_scalar_div;
  localparam int WIDTH = 32;
  localparam int SIZE  = 4;
  localparam int FRAC  = 16;
  localparam longint QMAX = 64'sd2147483647;
  localparam longint QMIN = -64'sd2147483648;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  vec_scalar_div_if #(.WIDTH(WIDTH), .SIZE(SIZE)) bus ();

  vec_scalar_div #(.WIDTH(WIDTH), .SIZE(SIZE), .FRAC(FRAC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Fixed-point quotient b/d * 2^FRAC, truncated toward zero, clamped.
  function automatic logic [31:0] ref_q(input logic [31:0] bv, input logic [31:0] dv);
    longint bl, dl, q;
    bl = longint'($signed(bv));
    dl = longint'($signed(dv));
    if (dl == 0) begin
      if (bl > 0) return 32'h7FFFFFFF;
      if (bl < 0) return 32'h80000000;
      return 32'h0;
    end
    q = (bl * 65536) / dl;
    if (q > QMAX) q = QMAX;
    if (q < QMIN) q = QMIN;
    return q[31:0];
  endfunction

  function automatic logic [3:0][31:0] mk(input logic [31:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction

  function automatic logic [3:0][31:0] ref_vec(input logic [31:0] dv, input logic [3:0][31:0] bv);
    logic [3:0][31:0] r;
    for (int i = 0; i < SIZE; i++) r[i] = ref_q(bv[i], dv);
    return r;
  endfunction

  // mode 0: plain op, 1: extra start during ITER, 2: reset at T0+50
  task automatic run_op(input string tag, input logic [31:0] dv, input logic [3:0][31:0] bv,
                        input logic [3:0][31:0] ev, input int mode);
    int busy_n, done_n, done_at;
    logic [3:0][31:0] yv;
    @(negedge clk);
    bus.start = 1'b1;
    bus.d     = dv;
    bus.b     = bv;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.d     = $urandom;
    bus.b     = {$urandom, $urandom, $urandom, $urandom};
    busy_n = 0; done_n = 0; done_at = -1;
    for (int c = 0; c < 205; c++) begin
      @(negedge clk);
      if (bus.busy) busy_n++;
      if (bus.done) begin
        done_n++;
        if (done_at < 0) done_at = c;
      end
      if (mode == 1 && c == 10) begin
        bus.start = 1'b1;
        bus.d     = 32'h00010000;
        bus.b     = mk(32'h00050000, 32'h00060000, 32'h00070000, 32'h00080000);
      end
      if (mode == 1 && c == 11) bus.start = 1'b0;
      if (mode == 2 && c == 49) rst_n = 1'b0;
      if (mode == 2 && c == 50) begin
        rst_n = 1'b1;
        chk({tag, "_rst_busy"}, 64'(bus.busy), 64'd0);
        chk({tag, "_rst_done"}, 64'(bus.done), 64'd0);
        chk({tag, "_rst_div0"}, 64'(bus.div0), 64'd0);
        chk({tag, "_rst_y"}, 64'(bus.y == '0), 64'd1);
      end
    end
    if (mode == 2) begin
      chk({tag, "_no_done"}, 64'(done_n), 64'd0);
      return;
    end
    chk({tag, "_busy_cycles"}, 64'(busy_n), 64'd200);
    chk({tag, "_done_at"}, 64'(done_at), 64'd200);
    chk({tag, "_done_pulses"}, 64'(done_n), 64'd1);
    chk({tag, "_div0"}, 64'(bus.div0), 64'(dv == 32'h0));
    yv = bus.y;
    for (int i = 0; i < SIZE; i++)
      chk($sformatf("%s_y%0d", tag, i), 64'(yv[i]), 64'(ev[i]));
  endtask

  initial begin
    logic [31:0] dv;
    logic [3:0][31:0] bv, ev;
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.start = 1'b1;
    bus.d = 32'h00010000;
    bus.b = '1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_done", 64'(bus.done), 64'd0);
    chk("reset_div0", 64'(bus.div0), 64'd0);
    chk("reset_y", 64'(bus.y == '0), 64'd1);
    bus.start = 1'b0;
    rst_n = 1'b1;

    run_op("basic", 32'h00020000,
           mk(32'h00010000, 32'h00020000, 32'hFFFD0000, 32'h00008000),
           mk(32'h00008000, 32'h00010000, 32'hFFFE8000, 32'h00004000), 0);
    run_op("trunc", 32'h00030000,
           mk(32'h00010000, 32'hFFFF0000, 32'h0, 32'h00000001),
           mk(32'h00005555, 32'hFFFFAAAB, 32'h0, 32'h0), 0);
    bv = mk(32'h7FFF0000, 32'h00000100, 32'h0, 32'hFFFFFF00);
    ev = ref_vec(32'h00000100, bv);
    ev[0] = 32'h7FFFFFFF;
    run_op("sat_pos", 32'h00000100, bv, ev, 0);
    bv = mk(32'h00001000, 32'h80000000, 32'hC0000000, 32'h00000000);
    ev = ref_vec(32'h00008000, bv);
    ev[1] = 32'h80000000;
    run_op("sat_neg", 32'h00008000, bv, ev, 0);
    bv = mk(32'h00010000, 32'hFFFF8000, 32'h80000000, 32'h7FFFFFFF);
    ev = ref_vec(32'hFFFF0000, bv);
    ev[2] = 32'h7FFFFFFF;
    run_op("sat_m1", 32'hFFFF0000, bv, ev, 0);
    run_op("div0", 32'h0,
           mk(32'h00010000, 32'hFFFF0000, 32'h0, 32'h7FFFFFFF),
           mk(32'h7FFFFFFF, 32'h80000000, 32'h0, 32'h7FFFFFFF), 0);
    bv = mk(32'h00030000, 32'hFFFA0000, 32'h00001234, 32'h00100000);
    run_op("ign_start", 32'h00040000, bv, ref_vec(32'h00040000, bv), 1);
    run_op("midrst", 32'h0, bv, bv, 2);
    run_op("after_rst", 32'h00020000,
           mk(32'h00010000, 32'h00020000, 32'hFFFD0000, 32'h00008000),
           mk(32'h00008000, 32'h00010000, 32'hFFFE8000, 32'h00004000), 0);

    for (int k = 0; k < 8; k++) begin
      case ($urandom_range(0, 3))
        0: dv = 32'h0;
        1: dv = 32'($signed($urandom_range(0, 65535)) - 32768);
        2: dv = $urandom;
        default: dv = $urandom_range(0, 1) ? 32'h00010000 : 32'hFFFE0000;
      endcase
      for (int i = 0; i < SIZE; i++)
        bv[i] = $urandom_range(0, 1) ? $urandom : 32'($signed($urandom_range(0, 1 << 20)) - (1 << 19));
      if (k == 0) bv[1] = 32'h0;
      run_op($sformatf("rnd%0d", k), dv, bv, ref_vec(dv, bv), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
